mem_bist: RTL and testbench

// - Self-contained memory BIST: 32x8 RAM, March C- controller, pattern generator, comparator, memory-interface mux.
// - go_bist with bist_en runs one March pass; bist_done flags completion; cmp_out is a sticky fail flag.
// - Internal control signals (state, counter, BIST-side address/data/enables) are exported for debug and coverage.

---
 rtl/mem_bist.sv | 153 +++++++++++++++
 tb/tb_mem_bist.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_bist.sv
// Self-contained memory BIST: 32x8 RAM, March C- sequencer, pattern generator,
// sticky comparator and BIST/functional memory-interface mux.
module mem_bist (
    input  logic       clk,
    input  logic       reset,
    input  logic       bist_en,
    input  logic       go_bist,
    output logic       cmp_out,
    output logic       cmp_en,
    output logic [7:0] data_out,
    output logic       bist_done,
    output logic [5:0] i,
    output logic [3:0] cs,
    output logic       test_pattern_gen_en,
    output logic [4:0] read_addr_out,
    output logic [4:0] write_addr_out,
    output logic [4:0] bistread_addr_in,
    output logic [4:0] bistwrite_addr_in,
    output logic [7:0] bistd_in,
    output logic [7:0] interface_data_out,
    output logic       bistwrite_en_in,
    output logic       bistread_en_in,
    output logic       write_en_out,
    output logic       read_en_out
);

    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_W0_UP   = 4'd1;
    localparam logic [3:0] S_R0W1_UP = 4'd2;
    localparam logic [3:0] S_R1W0_UP = 4'd3;
    localparam logic [3:0] S_R0W1_DN = 4'd4;
    localparam logic [3:0] S_R1W0_DN = 4'd5;
    localparam logic [3:0] S_R0_DN   = 4'd6;
    localparam logic [3:0] S_DONE    = 4'd7;

    logic [3:0] cs_q, cs_d;
    logic [5:0] i_q, i_d;
    logic       cmp_q, cmp_d;
    logic [7:0] dout_q;
    logic [7:0] mem_q [32];

    logic       rw_elem, elem_dn, last_addr;
    logic [4:0] addr_q, addr_step, next_start;
    logic [3:0] next_elem;
    logic [7:0] exp_data;

    // Element decode: direction, expected read value and next element start address
    assign addr_q     = i_q[4:0];
    assign rw_elem    = (cs_q >= S_R0W1_UP) && (cs_q <= S_R0_DN);
    assign elem_dn    = (cs_q >= S_R0W1_DN) && (cs_q <= S_R0_DN);
    assign last_addr  = elem_dn ? (addr_q == 5'd0) : (addr_q == 5'd31);
    assign addr_step  = elem_dn ? (addr_q - 5'd1) : (addr_q + 5'd1);
    assign next_elem  = cs_q + 4'd1;
    assign next_start = ((next_elem >= S_R0W1_DN) && (next_elem <= S_R0_DN)) ? 5'd31 : 5'd0;
    assign exp_data   = ((cs_q == S_R1W0_UP) || (cs_q == S_R1W0_DN)) ? 8'hFF : 8'h00;

    always_comb begin
        cs_d  = cs_q;
        i_d   = i_q;
        cmp_d = cmp_q;
        case (cs_q)
            S_IDLE: begin
                if (bist_en && go_bist) begin
                    cs_d  = S_W0_UP;
                    i_d   = 6'd0;
                    cmp_d = 1'b0;
                end
            end
            S_W0_UP: begin
                if (last_addr) begin
                    cs_d = S_R0W1_UP;
                    i_d  = 6'd0;
                end else begin
                    i_d = {1'b0, addr_step};
                end
            end
            S_R0W1_UP, S_R1W0_UP, S_R0W1_DN, S_R1W0_DN, S_R0_DN: begin
                if (!i_q[5]) begin
                    i_d = {1'b1, addr_q};
                end else if (last_addr) begin
                    cs_d = next_elem;
                    i_d  = {1'b0, next_start};
                end else begin
                    i_d = {1'b0, addr_step};
                end
            end
            S_DONE: begin
                if (!go_bist) begin
                    cs_d = S_IDLE;
                    i_d  = 6'd0;
                end
            end
            default: begin
                cs_d = S_IDLE;
                i_d  = 6'd0;
            end
        endcase
        if (cmp_en && (dout_q != exp_data))
            cmp_d = 1'b1;
        // Losing bist_en mid-test abandons the pass without flagging done
        if ((cs_q != S_IDLE) && !bist_en) begin
            cs_d = S_IDLE;
            i_d  = 6'd0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cs_q  <= S_IDLE;
            i_q   <= 6'd0;
            cmp_q <= 1'b0;
        end else begin
            cs_q  <= cs_d;
            i_q   <= i_d;
            cmp_q <= cmp_d;
        end
    end

    // BIST-side request generation
    assign bistread_en_in    = rw_elem && !i_q[5];
    assign cmp_en            = rw_elem && i_q[5];
    assign bistwrite_en_in   = (cs_q == S_W0_UP) || (rw_elem && i_q[5] && (cs_q != S_R0_DN));
    assign bistd_in          = ((cs_q == S_R0W1_UP) || (cs_q == S_R0W1_DN)) ? 8'hFF : 8'h00;
    assign bistread_addr_in  = addr_q;
    assign bistwrite_addr_in = addr_q;

    // Functional side is not modelled, so a deselected BIST path drives zeros
    assign read_addr_out      = bist_en ? bistread_addr_in  : 5'd0;
    assign write_addr_out     = bist_en ? bistwrite_addr_in : 5'd0;
    assign interface_data_out = bist_en ? bistd_in          : 8'd0;
    assign write_en_out       = bist_en && bistwrite_en_in;
    assign read_en_out        = bist_en && bistread_en_in;

    always_ff @(posedge clk) begin
        if (write_en_out)
            mem_q[write_addr_out] <= interface_data_out;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            dout_q <= 8'd0;
        else if (read_en_out)
            dout_q <= mem_q[read_addr_out];
    end

    assign cmp_out             = cmp_q;
    assign data_out            = dout_q;
    assign bist_done           = (cs_q == S_DONE);
    assign i                   = i_q;
    assign cs                  = cs_q;
    assign test_pattern_gen_en = (cs_q >= S_W0_UP) && (cs_q <= S_R0_DN);

endmodule

// File: tb/tb_mem_bist.sv
// Bench for mem_bist: expected March C- trace built from the element list,
// with a RAM model tracking writes, injected faults and the sticky fail flag.
module tb_mem_bist;
    logic       clk = 1'b0;
    logic       reset, bist_en, go_bist;
    logic       cmp_out, cmp_en, bist_done, test_pattern_gen_en;
    logic [7:0] data_out, bistd_in, interface_data_out;
    logic [5:0] i;
    logic [3:0] cs;
    logic [4:0] read_addr_out, write_addr_out, bistread_addr_in, bistwrite_addr_in;
    logic       bistwrite_en_in, bistread_en_in, write_en_out, read_en_out;

    mem_bist dut (
        .clk(clk), .reset(reset), .bist_en(bist_en), .go_bist(go_bist),
        .cmp_out(cmp_out), .cmp_en(cmp_en), .data_out(data_out), .bist_done(bist_done),
        .i(i), .cs(cs), .test_pattern_gen_en(test_pattern_gen_en),
        .read_addr_out(read_addr_out), .write_addr_out(write_addr_out),
        .bistread_addr_in(bistread_addr_in), .bistwrite_addr_in(bistwrite_addr_in),
        .bistd_in(bistd_in), .interface_data_out(interface_data_out),
        .bistwrite_en_in(bistwrite_en_in), .bistread_en_in(bistread_en_in),
        .write_en_out(write_en_out), .read_en_out(read_en_out)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        int         st;
        int         addr;
        bit         ph;
        bit         wen;
        logic [7:0] wd;
        bit         ren;
        bit         cmp;
        logic [7:0] ex;
    } step_t;

    step_t      tr[$];
    logic [7:0] mm [32];
    bit         exp_fail;

    // One entry per clock of a full pass, derived from the March C- element list
    task automatic build_trace();
        step_t s;
        tr.delete();
        for (int a = 0; a < 32; a++) begin
            s = '{st:1, addr:a, ph:0, wen:1, wd:8'h00, ren:0, cmp:0, ex:8'h00};
            tr.push_back(s);
        end
        for (int e = 0; e < 5; e++) begin
            bit dn, wr;
            logic [7:0] wd, ex;
            dn = (e >= 2);
            wr = (e < 4);
            wd = (e == 0 || e == 2) ? 8'hFF : 8'h00;
            ex = (e == 1 || e == 3) ? 8'hFF : 8'h00;
            for (int n = 0; n < 32; n++) begin
                int a;
                a = dn ? 31 - n : n;
                s = '{st:2+e, addr:a, ph:0, wen:0, wd:8'h00, ren:1, cmp:0, ex:ex};
                tr.push_back(s);
                s = '{st:2+e, addr:a, ph:1, wen:wr, wd:wd, ren:0, cmp:1, ex:ex};
                tr.push_back(s);
            end
        end
    endtask

    // Assumes go_bist/bist_en are already high ahead of the start edge
    task automatic run_pass(input int n, input bit inject, input int fa, input logic [7:0] fv);
        step_t s;
        exp_fail = 1'b0;
        for (int a = 0; a < 32; a++) mm[a] = 8'h00;
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            s = tr[k];
            if (inject && k == 288) begin
                dut.mem_q[fa] = fv;
                mm[fa] = fv;
            end
            chk("cs", cs, s.st);
            chk("i", i, {s.ph, s.addr[4:0]});
            chk("write_en_out", write_en_out, s.wen);
            chk("write_addr_out", write_addr_out, s.addr);
            chk("read_en_out", read_en_out, s.ren);
            chk("read_addr_out", read_addr_out, s.addr);
            chk("cmp_en", cmp_en, s.cmp);
            chk("tpg_en", test_pattern_gen_en, 1);
            chk("bist_done_run", bist_done, 0);
            chk("cmp_out_run", cmp_out, exp_fail);
            if (s.wen) chk("wdata", interface_data_out, s.wd);
            if (s.cmp) begin
                chk("data_out", data_out, mm[s.addr]);
                if (mm[s.addr] != s.ex) exp_fail = 1'b1;
            end
            if (s.wen) mm[s.addr] = s.wd;
        end
    endtask

    task automatic check_done();
        @(negedge clk);
        chk("done_cs", cs, 7);
        chk("done_flag", bist_done, 1);
        chk("done_tpg", test_pattern_gen_en, 0);
        chk("done_cmp_en", cmp_en, 0);
        chk("done_cmp_out", cmp_out, exp_fail);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        int fa, k;
        logic [7:0] fv;
        reset = 1'b1; bist_en = 1'b0; go_bist = 1'b0;
        build_trace();
        #7;
        chk("rst_cs", cs, 0);
        chk("rst_i", i, 0);
        chk("rst_cmp_out", cmp_out, 0);
        chk("rst_data_out", data_out, 0);
        chk("rst_done", bist_done, 0);
        chk("rst_en", {cmp_en, write_en_out, read_en_out, test_pattern_gen_en}, 0);
        #3;
        reset = 1'b0; bist_en = 1'b1; go_bist = 1'b1;

        // Clean pass, hold in DONE, release to IDLE
        run_pass(352, 0, 0, 8'h00);
        check_done();
        repeat (3) begin
            @(negedge clk);
            chk("done_hold", bist_done, 1);
        end
        go_bist = 1'b0;
        @(negedge clk);
        chk("idle_cs", cs, 0);
        chk("idle_done", bist_done, 0);
        chk("idle_cmp_out", cmp_out, 0);

        // Second pass with a stuck word injected just before R0_DN
        go_bist = 1'b1;
        fa = $urandom_range(0, 31);
        fv = 8'($urandom_range(1, 255));
        run_pass(352, 1, fa, fv);
        check_done();
        chk("fault_flag", cmp_out, 1);
        go_bist = 1'b0;
        @(negedge clk);
        chk("fault_idle_cs", cs, 0);
        chk("fault_hold", cmp_out, 1);

        // Abort while in R1W0_UP
        go_bist = 1'b1;
        k = $urandom_range(96, 159);
        run_pass(k + 1, 0, 0, 8'h00);
        bist_en = 1'b0;
        #1;
        chk("abort_mux", {read_addr_out, write_addr_out, interface_data_out, write_en_out, read_en_out}, 0);
        @(negedge clk);
        chk("abort_cs", cs, 0);
        chk("abort_i", i, 0);
        chk("abort_done", bist_done, 0);
        go_bist = 1'b0;
        bist_en = 1'b1;
        @(negedge clk);
        chk("abort_stay_idle", cs, 0);

        // Asynchronous reset mid-test, then start on the edge right after release
        go_bist = 1'b1;
        k = $urandom_range(95, 105);
        run_pass(k, 0, 0, 8'h00);
        #1 reset = 1'b1;
        #1;
        chk("mid_rst_cs", cs, 0);
        chk("mid_rst_i", i, 0);
        chk("mid_rst_data", data_out, 0);
        chk("mid_rst_flags", {cmp_out, cmp_en, bist_done, test_pattern_gen_en}, 0);
        chk("mid_rst_mux", {write_en_out, read_en_out, read_addr_out, write_addr_out, interface_data_out}, 0);
        bist_en = 1'b0; go_bist = 1'b0;
        @(negedge clk);
        reset = 1'b0; bist_en = 1'b1; go_bist = 1'b1;
        run_pass(352, 0, 0, 8'h00);
        check_done();
        go_bist = 1'b0;
        @(negedge clk);
        chk("final_idle", cs, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
